usb_in_ep_arb: RTL and testbench
================================

// Module: usb_in_ep_arb
// PURPOSE
//   Round-robin arbiter that shares one USB IN endpoint interface among NUM_EP
//   on-chip requesters (LED status, debug, command responders).
//   Sits between the requesters and the USB core's IN endpoint port.
//   Sequences request/grant, muxes the put/data/done/stall path from the current
//   owner, and forcibly revokes ownership from a requester that goes silent.
// PARAMETERS
//   NUM_EP    4     number of requesters, 2..8
//   IDLE_MAX  1023  cycles in ACTIVE with no owner put/done before forced release
// PORTS
//   clk              in   1         clock; all logic on posedge
//   reset            in   1         synchronous, active-high
//   req              in   NUM_EP    per-requester request, level, held until done
//   grant            out  NUM_EP    per-requester grant, registered, one-hot or zero
//   data_put         in   NUM_EP    per-requester byte strobe
//   data             in   8*NUM_EP  per-requester byte; requester i on [8i+7:8i]
//   data_done        in   NUM_EP    per-requester end-of-packet pulse
//   stall            in   NUM_EP    per-requester stall request
//   data_free        out  NUM_EP    core has space; asserted only to the granted requester
//   acked            out  NUM_EP    core ACK, routed to the last owner
//   in_ep_req        out  1         request to USB core, registered
//   in_ep_grant      in   1         core grant
//   in_ep_data_free  in   1         core buffer has space
//   in_ep_data_put   out  1         byte strobe to core
//   in_ep_data       out  8         byte to core
//   in_ep_data_done  out  1         packet-done pulse to core
//   in_ep_stall      out  1         stall to core
//   in_ep_acked      in   1         core ACK pulse
// BEHAVIOUR
//   Reset state:
//   - grant=0, in_ep_req=0, state=IDLE, owner=0, last=NUM_EP-1 (requester 0 wins first).
//   - idle counter=0; put/done/stall/data_free/acked outputs 0; in_ep_data=8'h00.
//   States: IDLE, WAIT_GRANT, ACTIVE, RELEASE.
//   - IDLE: if |req, owner <= first set req scanning last+1, last+2, ... modulo NUM_EP.
//     Also in_ep_req <= 1 and go to WAIT_GRANT. Decision is registered: one cycle from req to in_ep_req.
//   - WAIT_GRANT: in_ep_req held high.
//     If req[owner] falls -> RELEASE, and last is not updated.
//     Else if in_ep_grant -> ACTIVE, grant[owner] <= 1, last <= owner.
//   - ACTIVE: leave for RELEASE when any of these holds; grant and in_ep_req clear on the next edge:
//     (a) data_done[owner] is sampled high; it is forwarded that cycle;
//     (b) req[owner] falls;
//     (c) the idle counter reaches IDLE_MAX.
//     The idle counter is cleared on any data_put[owner]/data_done[owner] and increments otherwise.
//     If (a) and (c) coincide, treat the exit as (a): done is forwarded.
//   - RELEASE: exactly one cycle with grant=0 and in_ep_req=0, then IDLE.
//     This gives the core a guaranteed deassert gap.
//   Datapath, combinational, qualified by state==ACTIVE && grant[owner]:
//   - in_ep_data_put = data_put[owner] & in_ep_data_free
//   - in_ep_data = data[owner]; in_ep_data_done = data_done[owner]; in_ep_stall = stall[owner]
//   - data_free[i] = in_ep_data_free & grant[i]
//   - Outside ACTIVE, all of the above are 0 and in_ep_data=8'h00.
//     Puts, done or stall from non-owners are ignored.
//   - acked[i] = in_ep_acked & (i==owner).
//     owner holds until the next IDLE arbitration, so a late ACK after release still reaches the sender.
//   Boundaries:
//   - A new req arriving during ACTIVE or RELEASE waits for IDLE.
//   - If in_ep_grant drops mid-ACTIVE, puts are gated to 0 and ownership is kept.
//   - Reset mid-packet returns everything to reset values in one cycle. No done pulse is emitted.
// TESTING
//   1. Only req[2] set, core grants 2 cycles after in_ep_req.
//      Put 3 bytes 8'hA1,8'h02,8'h03, then done -> core sees the same 3 bytes then done.
//      grant goes 4'b0100 -> 0; exactly one RELEASE cycle.
//   2. req=4'b1111 held, each owner sends 1 byte + done -> grant sequence 0,1,2,3,0.
//      Every grant is separated by >=1 cycle of in_ep_req=0.
//   3. Owner 1 granted, never puts -> forced release after exactly IDLE_MAX+1 ACTIVE cycles.
//      Next winner is 2 when req=4'b0110.
//   4. Non-owner 3 pulses data_put with data 8'hFF while owner 0 is active -> in_ep_data_put never driven by it.
//      No 8'hFF reaches the core.
//   5. in_ep_data_free=0 while owner puts -> in_ep_data_put=0, data_free[owner]=0.
//      in_ep_acked one cycle after release -> acked[owner]=1, all other acked bits 0.
//   6. Reset asserted mid-packet -> next cycle: grant=0, in_ep_req=0, state IDLE.
//      With req=4'b1000 after reset release, requester 3 is granted.

Source files
------------

// File: rtl/usb_in_ep_arb.sv
// usb_in_ep_arb
//   Round-robin arbiter sharing one USB IN endpoint among NUM_EP requesters.
//   Arbitrates on req, requests the core endpoint, grants the winner, muxes
//   the winner's put/data/done/stall path to the core, and forcibly releases
//   an owner that stays silent for IDLE_MAX cycles.
// Ports
//   clk, reset              clock (posedge) and synchronous active-high reset
//   req/grant               per-requester request (level) / registered grant
//   data_put/data/data_done/stall   per-requester datapath inputs
//   data_free/acked         per-requester core status (owner only)
//   in_ep_req/in_ep_grant   request/grant handshake with the USB core
//   in_ep_data_free/in_ep_data_put/in_ep_data/in_ep_data_done/in_ep_stall/
//   in_ep_acked             muxed datapath to and status from the USB core
module usb_in_ep_arb #(
    parameter int NUM_EP   = 4,
    parameter int IDLE_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EP-1:0]     req,
    output logic [NUM_EP-1:0]     grant,
    input  logic [NUM_EP-1:0]     data_put,
    input  logic [8*NUM_EP-1:0]   data,
    input  logic [NUM_EP-1:0]     data_done,
    input  logic [NUM_EP-1:0]     stall,
    output logic [NUM_EP-1:0]     data_free,
    output logic [NUM_EP-1:0]     acked,
    output logic                  in_ep_req,
    input  logic                  in_ep_grant,
    input  logic                  in_ep_data_free,
    output logic                  in_ep_data_put,
    output logic [7:0]            in_ep_data,
    output logic                  in_ep_data_done,
    output logic                  in_ep_stall,
    input  logic                  in_ep_acked
);

    localparam int OW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int CW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_GRANT = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_RELEASE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [NUM_EP-1:0]   grant_q, grant_d;
    logic                in_ep_req_q, in_ep_req_d;
    logic [CW-1:0]       idle_cnt_q, idle_cnt_d;

    logic [OW-1:0]       pick_s;
    logic                found_s;
    logic                own_active_s;
    logic [7:0]          sel_data_s;
    logic [NUM_EP-1:0]   owner_onehot_s;

    // State register; owner and last survive release so late ACKs still route.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= {OW{1'b0}};
            last_q      <= OW'(NUM_EP - 1);
            grant_q     <= {NUM_EP{1'b0}};
            in_ep_req_q <= 1'b0;
            idle_cnt_q  <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            in_ep_req_q <= in_ep_req_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    // Round-robin pick: first set req scanning last+1, last+2, ... modulo NUM_EP.
    always_comb begin
        found_s = 1'b0;
        pick_s  = owner_q;
        for (int k = 1; k <= NUM_EP; k++) begin
            if (!found_s && req[(int'(last_q) + k) % NUM_EP]) begin
                found_s = 1'b1;
                pick_s  = OW'((int'(last_q) + k) % NUM_EP);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign owner_onehot_s = {{(NUM_EP-1){1'b0}}, 1'b1} << owner_q;

    // Next-state logic for arbitration, handshake and idle timeout.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_d     = grant_q;
        in_ep_req_d = in_ep_req_q;
        idle_cnt_d  = {CW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    owner_d     = pick_s;
                    in_ep_req_d = 1'b1;
                    state_d     = ST_WAIT_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_GRANT: begin
                // Withdrawal wins over a simultaneous core grant; last is kept.
                if (!req[owner_q]) begin
                    in_ep_req_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (in_ep_grant) begin
                    grant_d = owner_onehot_s;
                    last_d  = owner_q;
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_WAIT_GRANT;
                end
            end
            ST_ACTIVE: begin
                // Done, withdrawal or timeout all exit; done is still forwarded this cycle.
                if (data_done[owner_q] || !req[owner_q] || (idle_cnt_q == CW'(IDLE_MAX))) begin
                    grant_d     = {NUM_EP{1'b0}};
                    in_ep_req_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (data_put[owner_q]) begin
                    idle_cnt_d = {CW{1'b0}};
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d     = {NUM_EP{1'b0}};
                in_ep_req_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Byte mux from the current owner.
    always_comb begin
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (owner_q == OW'(i)) begin
                sel_data_s = data[8*i +: 8];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    assign own_active_s = (state_q == ST_ACTIVE) && grant_q[owner_q];

    // Puts are also gated by the core grant so a mid-packet grant drop stalls the stream.
    assign in_ep_data_put  = own_active_s & data_put[owner_q] & in_ep_data_free & in_ep_grant;
    assign in_ep_data      = own_active_s ? sel_data_s : 8'h00;
    assign in_ep_data_done = own_active_s & data_done[owner_q];
    assign in_ep_stall     = own_active_s & stall[owner_q];
    assign data_free       = {NUM_EP{own_active_s & in_ep_data_free}} & grant_q;
    assign acked           = in_ep_acked ? owner_onehot_s : {NUM_EP{1'b0}};
    assign grant           = grant_q;
    assign in_ep_req       = in_ep_req_q;

endmodule

// File: tb/tb_usb_in_ep_arb.sv
// Testbench for usb_in_ep_arb: directed vector table, hand-written corner
// sequences, and randomized traffic compared every cycle to a reference model.
module tb_usb_in_ep_arb;

    localparam int NEP  = 4;
    localparam int IMAX = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [NEP-1:0]    req, grant, put, done, stall, data_free, acked;
    logic [8*NEP-1:0]  data;
    logic              in_ep_req, cg, free, iput, idone, istall, ack;
    logic [7:0]        idata;

    int n_checks = 0;
    int n_pass   = 0;

    usb_in_ep_arb #(.NUM_EP(NEP), .IDLE_MAX(IMAX)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .data_put(put), .data(data), .data_done(done), .stall(stall),
        .data_free(data_free), .acked(acked), .in_ep_req(in_ep_req),
        .in_ep_grant(cg), .in_ep_data_free(free), .in_ep_data_put(iput),
        .in_ep_data(idata), .in_ep_data_done(idone), .in_ep_stall(istall),
        .in_ep_acked(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: who owns the endpoint, whether the core is requested,
    // whether the owner is streaming, whether we sit in the release gap.
    int m_owner, m_last, m_silent;
    bit m_req_out, m_on, m_gap;

    function automatic int rr_pick(input logic [NEP-1:0] r);
        for (int k = 1; k <= NEP; k++)
            if (r[(m_last + k) % NEP]) return (m_last + k) % NEP;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = NEP - 1; m_silent = 0;
        m_req_out = 1'b0; m_on = 1'b0; m_gap = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] e_grant, e_dfree, e_ack;
        logic [7:0] e_data;
        logic [31:0] e_all, a_all;
        int o;
        o       = m_owner;
        e_grant = m_on ? (4'b0001 << o) : 4'b0000;
        e_dfree = (m_on && free) ? e_grant : 4'b0000;
        e_ack   = ack ? (4'b0001 << o) : 4'b0000;
        e_data  = m_on ? 8'((data >> (8 * o)) & 32'hFF) : 8'h00;
        e_all = {5'd0, e_grant, m_req_out, m_on & put[o] & free & cg, e_data,
                 m_on & done[o], m_on & stall[o], e_dfree, e_ack};
        a_all = {5'd0, grant, in_ep_req, iput, idata, idone, istall, data_free, acked};
        check("model_cycle", a_all, e_all);
        if (reset) model_reset();
        else if (m_gap) m_gap = 1'b0;
        else if (m_on) begin
            if (done[o] || !req[o] || m_silent == IMAX) begin
                m_on = 1'b0; m_req_out = 1'b0; m_gap = 1'b1;
            end else m_silent = put[o] ? 0 : m_silent + 1;
        end else if (m_req_out) begin
            if (!req[o]) begin m_req_out = 1'b0; m_gap = 1'b1; end
            else if (cg) begin m_on = 1'b1; m_last = o; m_silent = 0; end
        end else if (rr_pick(req) >= 0) begin
            m_owner = rr_pick(req); m_req_out = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; put = '0; done = '0; stall = '0; data = '0;
        cg = 1'b0; free = 1'b0; ack = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]  req, put, done;
        logic [31:0] data;
        logic        free, cg, ack;
        logic [3:0]  e_grant;
        logic        e_ireq, e_put;
        logic [7:0]  e_data;
        logic        e_done;
        logic [3:0]  e_dfree, e_ack;
    } vec_t;

    vec_t tbl [12];

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < NEP; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int n, q[$];
        bit gap_seen;
        int put_mod;

        // Single requester 2, core grants two cycles after in_ep_req; 8'hFF from
        // non-owner 3, a put while the core is full, done, then ACKs after release.
        tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0100, 4'b0100, 4'b0000, 32'h00A10000, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0100, 4'b0000};
        tbl[5]  = '{4'b0100, 4'b1100, 4'b0000, 32'hFF020000, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h02, 1'b0, 4'b0100, 4'b0000};
        tbl[6]  = '{4'b0100, 4'b0100, 4'b0000, 32'h00550000, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h55, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0100, 4'b0100, 4'b0000, 32'h00030000, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h03, 1'b0, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b0100, 4'b0000, 4'b0100, 32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0100, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0100};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0100};

        model_reset();
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; put = tbl[i].put; done = tbl[i].done; data = tbl[i].data;
            free = tbl[i].free; cg = tbl[i].cg; ack = tbl[i].ack; stall = '0;
            @(negedge clk);
            check($sformatf("table_row%0d", i),
                  {9'd0, grant, in_ep_req, iput, idata, idone, data_free, acked},
                  {9'd0, tbl[i].e_grant, tbl[i].e_ireq, tbl[i].e_put, tbl[i].e_data,
                   tbl[i].e_done, tbl[i].e_dfree, tbl[i].e_ack});
            model_step();
            @(posedge clk);
            #1;
        end

        // All four requesting, one byte + done each: rotation 0,1,2,3,0 with gaps.
        reset_dut();
        req = 4'b1111; cg = 1'b1; free = 1'b1; data = 32'h13121110;
        gap_seen = 1'b0;
        for (int c = 0; c < 200 && q.size() < 5; c++) begin
            if (!in_ep_req) gap_seen = 1'b1;
            if (grant != 4'b0000) begin
                if (q.size() > 0) check("t2_gap_before_grant", 32'(gap_seen), 32'd1);
                q.push_back(oh_idx(grant));
                gap_seen = 1'b0;
                put = grant; done = grant;
            end else begin
                put = '0; done = '0;
            end
            cycle();
        end
        check("t2_grant_count", q.size(), 5);
        for (int i = 0; i < q.size(); i++) check($sformatf("t2_seq%0d", i), q[i], i % NEP);
        put = '0; done = '0;

        // Silent owner 1 is forcibly released after IMAX+1 active cycles; 2 wins next.
        reset_dut();
        req = 4'b0010; cg = 1'b1; free = 1'b1;
        for (int w = 0; w < 50 && grant != 4'b0010; w++) cycle();
        check("t3_owner1_granted", grant, 4'b0010);
        req = 4'b0110;
        n = 0;
        while (grant == 4'b0010 && n < 5 * IMAX) begin n++; cycle(); end
        check("t3_active_cycles", n, IMAX + 1);
        for (int w = 0; w < 50 && grant == 4'b0000; w++) cycle();
        check("t3_next_winner", grant, 4'b0100);

        // Reset mid-packet, then requester 3 alone is granted.
        reset_dut();
        req = 4'b0001; cg = 1'b1; free = 1'b1; data = 32'h000000C3;
        for (int w = 0; w < 50 && grant != 4'b0001; w++) cycle();
        check("t6_owner0_granted", grant, 4'b0001);
        put = 4'b0001;
        cycle();
        reset = 1'b1;
        cycle();
        check("t6_grant_after_reset", grant, 4'b0000);
        check("t6_req_after_reset", in_ep_req, 1'b0);
        check("t6_done_after_reset", idone, 1'b0);
        check("t6_data_after_reset", idata, 8'h00);
        reset = 1'b0; put = '0; req = 4'b1000;
        for (int w = 0; w < 50 && grant == 4'b0000; w++) cycle();
        check("t6_requester3_granted", grant, 4'b1000);

        // Randomized traffic against the model, alternating busy and sparse put rates.
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            put_mod = ((c / 500) % 2 == 0) ? 2 : 30;
            for (int i = 0; i < NEP; i++) begin
                if (req[i]) req[i] = ($urandom_range(39) != 0);
                else        req[i] = ($urandom_range(9) == 0);
                put[i]   = ($urandom_range(put_mod - 1) == 0);
                done[i]  = ($urandom_range(15) == 0);
                stall[i] = ($urandom_range(7) == 0);
            end
            data  = $urandom;
            free  = ($urandom_range(3) != 0);
            cg    = ($urandom_range(7) != 0);
            ack   = ($urandom_range(9) == 0);
            reset = ($urandom_range(399) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
